bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: bus wait cycles without mem_ack_i before abort; range 1..255.
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- if_req_i  in  1  fetch request, held until if_ack_o.
- if_addr_i  in  32  fetch address.
- if_ack_o  out  1  fetch complete.
- if_rdata_o  out  32  fetched instruction.
- d_req_i  in  1  data request, held until d_ack_o.
- d_we_i  in  1  1 = store.
- d_be_i  in  4  byte enables.
- d_addr_i  in  32  data address.
- d_wdata_i  in  32  store data.
- d_ack_o  out  1  data access complete.
- d_rdata_o  out  32  load data.
- flush_i  in  1  branch taken; kill in-flight fetch.
- mem_req_o  out  1  bus request, held until mem_ack_i.
- mem_we_o  out  1  bus write.
- mem_be_o  out  4  bus byte enables.
- mem_addr_o  out  32  bus address.
- mem_wdata_o  out  32  bus write data.
- mem_rdata_i  in  32  bus read data.
- mem_ack_i  in  1  bus completion, one cycle.
- if_stall_o  out  1  freeze PC/IF.
- d_stall_o  out  1  freeze pipeline at MEM.
- err_o  out  1  sticky bus timeout.

Function
REQ-003 SHALL implement the FSM states IDLE, IFETCH, DATA and DRAIN.
REQ-004 IDLE with d_req_i: SHALL register d_* into bus registers, mem_we_o = d_we_i, and go to DATA; data wins over fetch in the same cycle.
REQ-005 IDLE with if_req_i, no d_req_i, no flush_i: SHALL register if_addr_i, mem_we_o = 0, mem_be_o = 4'hF, and go to IFETCH.
REQ-006 IDLE with flush_i: SHALL not grant fetch that cycle; data grant unaffected.
REQ-007 mem_req_o SHALL be 1 exactly in IFETCH, DATA and DRAIN; bus address and data outputs SHALL be stable while mem_req_o = 1.
REQ-008 DATA with mem_ack_i: SHALL assert d_ack_o combinationally that cycle, d_rdata_o = mem_rdata_i, and next state IDLE.
REQ-009 IFETCH with mem_ack_i and no flush_i: SHALL assert if_ack_o that cycle, if_rdata_o = mem_rdata_i, and next state IDLE.
REQ-010 IFETCH with flush_i and mem_ack_i: SHALL suppress if_ack_o and go to IDLE.
REQ-011 IFETCH with flush_i and no mem_ack_i: SHALL go to DRAIN.
REQ-012 DRAIN: SHALL hold mem_req_o, swallow mem_ack_i (no if_ack_o), then go to IDLE.
REQ-013 Minimum latency: request cycle N -> mem_req_o cycle N+1 -> ack earliest N+1.
REQ-014 if_stall_o SHALL equal if_req_i & ~if_ack_o; d_stall_o SHALL equal d_req_i & ~d_ack_o.
REQ-015 Wait counter, 8 bits: SHALL clear on every grant and increment each busy cycle without mem_ack_i.
REQ-016 Counter reaching TIMEOUT: SHALL abort: set err_o, ack the owner with rdata 0 (none in DRAIN), and go to IDLE.
REQ-017 err_o SHALL hold until reset; later requests SHALL still be served.
REQ-018 if_rdata_o and d_rdata_o SHALL be 0 when the matching ack is 0.
REQ-019 mem_ack_i in IDLE SHALL be ignored.

Reset
REQ-020 rst_i SHALL force, asynchronously: state IDLE, counter 0, err_o 0, all bus outputs 0, all acks 0, even mid-transaction.
REQ-021 First grant SHALL be possible in the first clock edge after rst_i deasserts.

Structure
REQ-022 Package bus_pkg SHALL hold enum arb_state_t {ARB_IDLE, ARB_IFETCH, ARB_DATA, ARB_DRAIN} and constant TIMEOUT_DEFAULT = 255.
REQ-023 Wait counter SHALL be sub-module bus_timer (clear, enable, terminal-count output).

Verification
REQ-024 if_req_i and d_req_i rise together, ack after 2 cycles -> data served first, if_stall_o = 1 throughout, fetch granted the cycle after d_ack_o.
REQ-025 Load: d_addr_i = 32'h100, mem_rdata_i = 32'hDEADBEEF, ack in cycle N+1 -> d_ack_o and d_rdata_o = 32'hDEADBEEF in cycle N+1.
REQ-026 flush_i during fetch, ack 3 cycles later -> DRAIN, no if_ack_o, mem_req_o held until ack.
REQ-027 flush_i with mem_ack_i in the same cycle -> if_ack_o = 0, IDLE next.
REQ-028 TIMEOUT = 4, no ack -> abort after 4 wait cycles, err_o = 1 sticky, d_ack_o with rdata 0, next request served.
REQ-029 rst_i mid-DATA -> mem_req_o = 0 before the next edge, IDLE after release.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the instruction/data bus arbiter.
package bus_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_IFETCH,
      ARB_DATA,
      ARB_DRAIN
   } arb_state_t;

   localparam int unsigned TIMEOUT_DEFAULT = 255;
   localparam int unsigned WAIT_W          = 8;
   localparam logic [3:0]  BE_WORD         = 4'hF;

endpackage

// File: rtl/bus_timer.sv
// Bus wait counter: cleared on grant, counts stalled bus cycles.
module bus_timer
   import bus_pkg::*;
#(
   parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic en_i,
   output logic tc_o
);

   logic [WAIT_W-1:0] count;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count <= '0;
      end else if (clear_i) begin
         count <= '0;
      end else if (en_i) begin
         count <= count + 1'b1;
      end
   end

   assign tc_o = (count == WAIT_W'(LIMIT));

endmodule

// File: rtl/bus_arbiter.sv
// Single-master bus arbiter between IF and MEM stages; data has priority,
// flush kills in-flight fetches, and a wait timer aborts hung transfers.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_ack_o,
   output logic [31:0] if_rdata_o,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [3:0]  d_be_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   output logic        d_ack_o,
   output logic [31:0] d_rdata_o,
   input  logic        flush_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i,
   output logic        if_stall_o,
   output logic        d_stall_o,
   output logic        err_o
);

   arb_state_t  state;
   arb_state_t  state_nxt;
   logic        busy;
   logic        grant_d;
   logic        grant_if;
   logic        tc;
   logic        abort;
   logic        done;
   logic        err_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   assign busy     = (state != ARB_IDLE);
   assign grant_d  = (state == ARB_IDLE) & d_req_i;
   assign grant_if = (state == ARB_IDLE) & ~d_req_i
                   & if_req_i & ~flush_i;
   // A real ack always beats a timeout landing in the same cycle
   assign abort    = busy & tc & ~mem_ack_i;
   assign done     = mem_ack_i | abort;

   bus_timer #(
      .LIMIT (TIMEOUT)
   ) u_timer (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (grant_d | grant_if),
      .en_i    (busy & ~mem_ack_i & ~tc),
      .tc_o    (tc)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_q    <= 1'b0;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (grant_d) begin
         we_q    <= d_we_i;
         be_q    <= d_be_i;
         addr_q  <= d_addr_i;
         wdata_q <= d_wdata_i;
      end else if (grant_if) begin
         we_q    <= 1'b0;
         be_q    <= BE_WORD;
         addr_q  <= if_addr_i;
         wdata_q <= '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (abort) begin
         err_q <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      d_ack_o   = 1'b0;
      if_ack_o  = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            if (grant_d) begin
               state_nxt = ARB_DATA;
            end else if (grant_if) begin
               state_nxt = ARB_IFETCH;
            end
         end
         ARB_DATA: begin
            if (done) begin
               d_ack_o   = 1'b1;
               state_nxt = ARB_IDLE;
            end
         end
         ARB_IFETCH: begin
            if (done) begin
               if_ack_o  = ~flush_i;
               state_nxt = ARB_IDLE;
            end else if (flush_i) begin
               state_nxt = ARB_DRAIN;
            end
         end
         ARB_DRAIN: begin
            if (done) begin
               state_nxt = ARB_IDLE;
            end
         end
         default: begin
            state_nxt = ARB_IDLE;
         end
      endcase
   end

   assign d_rdata_o  = (d_ack_o & mem_ack_i) ? mem_rdata_i : '0;
   assign if_rdata_o = (if_ack_o & mem_ack_i) ? mem_rdata_i : '0;

   assign if_stall_o = if_req_i & ~if_ack_o;
   assign d_stall_o  = d_req_i & ~d_ack_o;

   assign mem_req_o   = busy;
   assign mem_we_o    = we_q;
   assign mem_be_o    = be_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios plus random CPU/memory traffic.
module tb_bus_arbiter;

   localparam int unsigned TO = 4;

   typedef struct {
      logic        chk;
      logic [31:0] data;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = '0;
   logic        if_ack_o;
   logic [31:0] if_rdata_o;
   logic        d_req_i = 1'b0;
   logic        d_we_i = 1'b0;
   logic [3:0]  d_be_i = '0;
   logic [31:0] d_addr_i = '0;
   logic [31:0] d_wdata_i = '0;
   logic        d_ack_o;
   logic [31:0] d_rdata_o;
   logic        flush_i = 1'b0;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i = '0;
   logic        mem_ack_i = 1'b0;
   logic        if_stall_o;
   logic        d_stall_o;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   exp_t d_q[$];
   exp_t if_q[$];
   logic [31:0] ref_mem [logic [31:0]];
   logic [7:0]  bmem [logic [31:0]];

   exp_t        e;
   logic        m_prev = 1'b0;
   int          m_cnt = 0;
   int          m_dly = 1;
   logic        d_done = 1'b0;
   logic        i_done = 1'b0;
   int          d_wait = 0;
   int          i_wait = 0;
   logic        issue = 1'b0;

   exp_t        me;
   logic        mon_prev = 1'b0;
   logic [31:0] h_addr = '0;
   logic [31:0] h_wdata = '0;
   logic [31:0] h_ctl = '0;

   bus_arbiter #(
      .TIMEOUT (TO)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_ack_o    (if_ack_o),
      .if_rdata_o  (if_rdata_o),
      .d_req_i     (d_req_i),
      .d_we_i      (d_we_i),
      .d_be_i      (d_be_i),
      .d_addr_i    (d_addr_i),
      .d_wdata_i   (d_wdata_i),
      .d_ack_o     (d_ack_o),
      .d_rdata_o   (d_rdata_o),
      .flush_i     (flush_i),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_be_o    (mem_be_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ack_i   (mem_ack_i),
      .if_stall_o  (if_stall_o),
      .d_stall_o   (d_stall_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] bus_read(input logic [31:0] a);
      logic [31:0] w;
      logic [31:0] r;
      w = dflt(a);
      for (int b = 0; b < 4; b++) begin
         if (bmem.exists(a + 32'(b))) r[8*b +: 8] = bmem[a + 32'(b)];
         else r[8*b +: 8] = w[8*b +: 8];
      end
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic mem_drive();
      if (mem_req_o) begin
         if (!m_prev) begin
            m_cnt = 1;
            m_dly = int'($urandom_range(1, 4));
         end else begin
            m_cnt++;
         end
         if (m_cnt == m_dly) begin
            mem_ack_i = 1'b1;
            if (mem_we_o) begin
               for (int b = 0; b < 4; b++) begin
                  if (mem_be_o[b])
                     bmem[mem_addr_o + 32'(b)] = mem_wdata_o[8*b +: 8];
               end
               mem_rdata_i = $urandom;
            end else begin
               mem_rdata_i = bus_read(mem_addr_o);
            end
         end else begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = $urandom;
         end
      end else begin
         mem_ack_i   = ($urandom_range(0, 7) == 0);
         mem_rdata_i = $urandom;
      end
      m_prev = mem_req_o;
   endtask

   task automatic new_fetch();
      exp_t f;
      if_addr_i = 32'h8000_0000 + 32'(4 * $urandom_range(0, 1023));
      f.chk  = 1'b1;
      f.data = dflt(if_addr_i);
      if_q.push_back(f);
      if_req_i = 1'b1;
      i_wait   = 0;
   endtask

   task automatic new_data();
      exp_t f;
      logic [31:0] cur;
      d_we_i    = 1'($urandom_range(0, 1));
      d_addr_i  = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      d_be_i    = d_we_i ? 4'($urandom_range(1, 15)) : 4'hF;
      d_wdata_i = $urandom;
      cur = ref_mem.exists(d_addr_i) ? ref_mem[d_addr_i] : dflt(d_addr_i);
      if (d_we_i) begin
         ref_mem[d_addr_i] = merge(cur, d_wdata_i, d_be_i);
         f.chk  = 1'b0;
         f.data = '0;
      end else begin
         f.chk  = 1'b1;
         f.data = cur;
      end
      d_q.push_back(f);
      d_req_i = 1'b1;
      d_wait  = 0;
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk_i);
         chk("if_stall", if_stall_o, if_req_i & ~if_ack_o);
         chk("d_stall", d_stall_o, d_req_i & ~d_ack_o);
         if (!d_ack_o) chk("d_rdata_zero", d_rdata_o, 0);
         if (!if_ack_o) chk("if_rdata_zero", if_rdata_o, 0);
         if (flush_i) chk("if_ack_on_flush", if_ack_o, 0);
         if (d_ack_o) begin
            if (d_q.size() == 0) begin
               chk("d_ack_unexpected", d_ack_o, 0);
            end else begin
               me = d_q.pop_front();
               if (me.chk) chk("d_rdata", d_rdata_o, me.data);
            end
         end
         if (if_ack_o) begin
            if (if_q.size() == 0) begin
               chk("if_ack_unexpected", if_ack_o, 0);
            end else begin
               me = if_q.pop_front();
               if (me.chk) chk("if_rdata", if_rdata_o, me.data);
            end
         end
         if (mem_req_o) begin
            if (mon_prev) begin
               chk("bus_addr_stable", mem_addr_o, h_addr);
               chk("bus_wdata_stable", mem_wdata_o, h_wdata);
               chk("bus_ctl_stable", {27'd0, mem_we_o, mem_be_o}, h_ctl);
            end
            h_addr  = mem_addr_o;
            h_wdata = mem_wdata_o;
            h_ctl   = {27'd0, mem_we_o, mem_be_o};
         end
         mon_prev = mem_req_o;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      d_req_i  = 1'b1;
      d_we_i   = 1'b0;
      d_be_i   = 4'hF;
      d_addr_i = 32'h100;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_d_ack", d_ack_o, 0);

      // Load right out of reset: grant on first edge, ack next cycle
      e.chk = 1'b1; e.data = 32'hDEADBEEF; d_q.push_back(e);
      cyc(); rst_i = 1'b0;
      #3; chk("ld_idle_req", mem_req_o, 0);
      cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
      #3;
      chk("ld_mem_req", mem_req_o, 1);
      chk("ld_addr", mem_addr_o, 32'h100);
      chk("ld_we", mem_we_o, 0);
      chk("ld_d_ack", d_ack_o, 1);
      chk("ld_rdata", d_rdata_o, 32'hDEADBEEF);
      cyc(); d_req_i = 1'b0; mem_ack_i = 1'b0;
      #3; chk("ld_done", mem_req_o, 0);

      // Simultaneous requests: data first, fetch after d_ack
      cyc();
      d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'h3;
      d_addr_i = 32'h2000; d_wdata_i = 32'h1234_5678;
      if_req_i = 1'b1; if_addr_i = 32'h8000_0010;
      e.chk = 1'b0; e.data = '0; d_q.push_back(e);
      e.chk = 1'b1; e.data = 32'h13; if_q.push_back(e);
      #3; chk("pr_stall_a", if_stall_o, 1);
      cyc(); #3;
      chk("pr_we", mem_we_o, 1);
      chk("pr_addr", mem_addr_o, 32'h2000);
      chk("pr_be", mem_be_o, 4'h3);
      chk("pr_wdata", mem_wdata_o, 32'h1234_5678);
      cyc(); #3; chk("pr_stall_b", if_stall_o, 1);
      cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
      #3; chk("pr_d_ack", d_ack_o, 1); chk("pr_stall_c", if_stall_o, 1);
      cyc(); mem_ack_i = 1'b0; d_req_i = 1'b0;
      #3; chk("pr_idle", mem_req_o, 0); chk("pr_stall_d", if_stall_o, 1);
      cyc(); #3;
      chk("pr_if_addr", mem_addr_o, 32'h8000_0010);
      chk("pr_if_be", mem_be_o, 4'hF);
      chk("pr_if_we", mem_we_o, 0);
      cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'h13;
      #3; chk("pr_if_ack", if_ack_o, 1);
      cyc(); mem_ack_i = 1'b0; if_req_i = 1'b0;

      // Flush mid-fetch, ack three cycles later is swallowed
      cyc(); if_req_i = 1'b1; if_addr_i = 32'h8000_0020;
      e.chk = 1'b1; e.data = 32'h0; if_q.push_back(e);
      #3;
      cyc(); flush_i = 1'b1; e = if_q.pop_back();
      #3; chk("fl_req", mem_req_o, 1); chk("fl_if_ack", if_ack_o, 0);
      cyc(); flush_i = 1'b0; if_req_i = 1'b0;
      #3; chk("fl_drain1", mem_req_o, 1);
      cyc(); #3; chk("fl_drain2", mem_req_o, 1);
      cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'h77;
      #3; chk("fl_drain3", mem_req_o, 1); chk("fl_swallow", if_ack_o, 0);
      cyc(); mem_ack_i = 1'b0;
      #3; chk("fl_done", mem_req_o, 0);

      // Flush coinciding with the fetch ack
      cyc(); if_req_i = 1'b1; if_addr_i = 32'h8000_0030;
      e.chk = 1'b1; e.data = 32'h0; if_q.push_back(e);
      #3;
      cyc(); flush_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h99;
      e = if_q.pop_back();
      #3; chk("fa_if_ack", if_ack_o, 0); chk("fa_if_rdata", if_rdata_o, 0);
      cyc(); flush_i = 1'b0; mem_ack_i = 1'b0; if_req_i = 1'b0;
      #3; chk("fa_idle", mem_req_o, 0);

      // Random CPU and memory traffic against the reference model
      for (int c = 0; c < 2500; c++) begin
         cyc();
         issue   = (c < 2400);
         flush_i = 1'b0;
         if (d_req_i && d_done) begin
            d_req_i = 1'b0;
         end else if (d_req_i && d_wait > 40) begin
            chk("d_ack_wait", d_done, 1);
            d_q.delete();
            d_req_i = 1'b0;
         end else if (!d_req_i && issue && $urandom_range(0, 2) == 0) begin
            new_data();
         end else if (!d_req_i) begin
            d_addr_i  = $urandom;
            d_wdata_i = $urandom;
            d_we_i    = 1'($urandom_range(0, 1));
         end
         if (if_req_i && i_done) begin
            if_req_i = 1'b0;
            if (issue && $urandom_range(0, 1) == 0) new_fetch();
         end else if (if_req_i && i_wait > 40) begin
            chk("if_ack_wait", i_done, 1);
            if_q.delete();
            if_req_i = 1'b0;
         end else if (if_req_i && issue && $urandom_range(0, 9) == 0) begin
            flush_i = 1'b1;
            if (if_q.size() > 0) e = if_q.pop_back();
            new_fetch();
         end else if (!if_req_i && issue && $urandom_range(0, 1) == 0) begin
            new_fetch();
         end else if (!if_req_i && issue && $urandom_range(0, 15) == 0) begin
            flush_i = 1'b1;
         end
         mem_drive();
         #3;
         d_done = d_ack_o;
         i_done = if_ack_o;
         if (d_req_i && !d_done) d_wait++;
         if (if_req_i && !i_done) i_wait++;
      end
      cyc(); d_req_i = 1'b0; if_req_i = 1'b0; flush_i = 1'b0;
      mem_ack_i = 1'b0; m_prev = 1'b0;
      #3; chk("rand_err", err_o, 0); chk("rand_idle", mem_req_o, 0);

      // Timeout: no ack for TO wait cycles aborts the load
      cyc(); d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF;
      d_addr_i = 32'h3000;
      e.chk = 1'b1; e.data = 32'h0; d_q.push_back(e);
      #3;
      for (int k = 1; k <= int'(TO); k++) begin
         cyc(); mem_rdata_i = $urandom;
         #3; chk("to_wait_d_ack", d_ack_o, 0); chk("to_wait_req", mem_req_o, 1);
      end
      cyc(); mem_rdata_i = 32'hFFFF_FFFF;
      #3; chk("to_abort_d_ack", d_ack_o, 1); chk("to_abort_rdata", d_rdata_o, 0);
      cyc(); d_req_i = 1'b0;
      #3; chk("to_err", err_o, 1); chk("to_idle", mem_req_o, 0);
      cyc(); d_req_i = 1'b1; d_addr_i = 32'h3004;
      e.chk = 1'b1; e.data = 32'hCAFE_F00D; d_q.push_back(e);
      #3;
      cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
      #3; chk("to_next_d_ack", d_ack_o, 1); chk("to_err_sticky", err_o, 1);
      cyc(); d_req_i = 1'b0; mem_ack_i = 1'b0;

      // Reset in the middle of a data transfer
      cyc(); d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h4000;
      d_wdata_i = 32'hA5A5_0F0F;
      e.chk = 1'b0; e.data = '0; d_q.push_back(e);
      #3;
      cyc(); chk("rm_req_pre", mem_req_o, 1);
      rst_i = 1'b1;
      #1;
      chk("rm_req", mem_req_o, 0);
      chk("rm_addr", mem_addr_o, 0);
      chk("rm_err", err_o, 0);
      chk("rm_d_ack", d_ack_o, 0);
      e = d_q.pop_front();
      d_req_i = 1'b0;
      cyc(); rst_i = 1'b0;
      #3; chk("rm_idle", mem_req_o, 0);
      cyc(); d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h4004;
      e.chk = 1'b1; e.data = 32'h0BAD_CAFE; d_q.push_back(e);
      #3;
      cyc(); mem_ack_i = 1'b1; mem_rdata_i = 32'h0BAD_CAFE;
      #3; chk("rm_next_d_ack", d_ack_o, 1);
      cyc(); d_req_i = 1'b0; mem_ack_i = 1'b0;
      #3;

      chk("sb_d_empty", d_q.size(), 0);
      chk("sb_if_empty", if_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
